// File: rtl/div_pkg.sv
// Shared types for the restoring divider sequencer: FSM state encoding and
// counter width helper.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABS_A = 3'd1,
    ABS_B = 3'd2,
    CALC  = 3'd3,
    FIX_Q = 3'd4,
    FIX_R = 3'd5,
    DONE  = 3'd6
  } state_e;

  localparam int unsigned BIT_DEF = 32;
  localparam int unsigned CNT_W   = $clog2(BIT_DEF);

  // Step counter width for an arbitrary operand width.
  function automatic int unsigned cnt_w(input int unsigned bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/add_subtract.sv
// Shared ripple adder/subtractor: result = a + (sub ? ~b : b) + cin, with
// carry out (for subtract with cin=1, cout=1 means a >= b).
module add_subtract #(
  parameter int unsigned BIT = 32
) (
  input  logic [BIT-1:0] a_i,
  input  logic [BIT-1:0] b_i,
  input  logic           sub_i,
  input  logic           cin_i,
  output logic [BIT-1:0] result_o,
  output logic           cout_o
);

  logic [BIT-1:0] b_eff;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign {cout_o, result_o} = {1'b0, a_i} + {1'b0, b_eff} + {{BIT{1'b0}}, cin_i};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring DIV/REM unit built around one shared add_subtract.
// Optional signed support is enabled by defining DIV_SIGNED_EN.
module div_sequencer
  import div_pkg::*;
#(
  parameter int unsigned BIT = 32
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic           sign_i,
  input  logic [BIT-1:0] dividend_i,
  input  logic [BIT-1:0] divisor_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [BIT-1:0] quotient_o,
  output logic [BIT-1:0] remainder_o,
  output logic           div0_o
);

  localparam int unsigned CW = cnt_w(BIT);

  state_e         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [BIT-1:0] q, rem, dvs;

  logic [BIT-1:0] add_a, add_b, add_res;
  logic           add_cout;

  logic [BIT-1:0] s_low, calc_q, calc_rem;
  logic           step_ok;
  logic [BIT-1:0] out_q_nxt, out_r_nxt;
  logic           out_load;

`ifdef DIV_SIGNED_EN
  logic sgn, neg_q, neg_r;
`else
  logic unused_sign;
  assign unused_sign = sign_i;
`endif

  add_subtract #(.BIT(BIT)) u_addsub (
    .a_i      (add_a),
    .b_i      (add_b),
    .sub_i    (1'b1),
    .cin_i    (1'b1),
    .result_o (add_res),
    .cout_o   (add_cout)
  );

  // One restoring step: shift {rem,q} left one bit and try to subtract.
  assign s_low    = {rem[BIT-2:0], q[BIT-1]};
  assign step_ok  = rem[BIT-1] | add_cout;
  assign calc_q   = {q[BIT-2:0], step_ok};
  assign calc_rem = step_ok ? add_res : s_low;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    add_a     = s_low;
    add_b     = dvs;
    out_q_nxt = calc_q;
    out_r_nxt = calc_rem;
    case (state)
      IDLE: begin
        out_q_nxt = '1;
        out_r_nxt = dividend_i;
        if (start_i) begin
          if (divisor_i == '0) state_nxt = DONE;
`ifdef DIV_SIGNED_EN
          else if (sign_i)     state_nxt = ABS_A;
`endif
          else                 state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
`ifdef DIV_SIGNED_EN
          state_nxt = sgn ? FIX_Q : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      // Negation steps reuse the adder as 0 - x.
      ABS_A: begin
        add_a     = '0;
        add_b     = q;
        state_nxt = ABS_B;
      end
      ABS_B: begin
        add_a     = '0;
        add_b     = dvs;
        state_nxt = CALC;
      end
      FIX_Q: begin
        add_a     = '0;
        add_b     = q;
        state_nxt = FIX_R;
      end
      FIX_R: begin
        add_a     = '0;
        add_b     = rem;
        out_q_nxt = q;
        out_r_nxt = neg_r ? add_res : rem;
        state_nxt = DONE;
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign out_load = (state_nxt == DONE) && (state != DONE);
  assign busy_o   = (state != IDLE) && (state != DONE);
  assign done_o   = (state == DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt   <= '0;
      q     <= '0;
      rem   <= '0;
      dvs   <= '0;
`ifdef DIV_SIGNED_EN
      sgn   <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start_i) begin
          q     <= dividend_i;
          dvs   <= divisor_i;
          rem   <= '0;
          cnt   <= CW'(BIT - 1);
`ifdef DIV_SIGNED_EN
          sgn   <= sign_i;
          neg_q <= sign_i & (dividend_i[BIT-1] ^ divisor_i[BIT-1]);
          neg_r <= sign_i & dividend_i[BIT-1];
`endif
        end
        CALC: begin
          q   <= calc_q;
          rem <= calc_rem;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
`ifdef DIV_SIGNED_EN
        ABS_A: if (neg_r) q <= add_res;
        ABS_B: if (sgn && dvs[BIT-1]) dvs <= add_res;
        FIX_Q: if (neg_q) q <= add_res;
        FIX_R: if (neg_r) rem <= add_res;
`endif
        default: ;
      endcase
    end
  end

  // Visible results change only when DONE is entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quotient_o  <= '0;
      remainder_o <= '0;
      div0_o      <= 1'b0;
    end else if (out_load) begin
      quotient_o  <= out_q_nxt;
      remainder_o <= out_r_nxt;
      div0_o      <= (state == IDLE);
    end
  end

endmodule
